// File: rtl/s1_cnt_launcher.sv
// s1_cnt_launcher: per-frame event counter and launcher/result holder for the s1 calculator.
// Define S1_TIMEOUT_EN to bound the wait for i_s1_vld to TIMEOUT_CYC cycles.
module s1_cnt_launcher #(
    parameter int TIMEOUT_CYC = 1024,
    parameter int TO_W        = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_frame_start,
    input  logic        i_frame_end,
    input  logic        i_evt_vld,
    input  logic [1:0]  i_evt_type,
    output logic [20:0] o_nv,
    output logic [24:0] o_nu,
    output logic [20:0] o_no,
    output logic        o_s1_start,
    input  logic        i_s1_busy,
    input  logic [31:0] i_s1,
    input  logic        i_s1_vld,
    input  logic        i_s1_error,
    output logic [31:0] o_res_s1,
    output logic        o_res_err,
    output logic        o_res_sat,
    output logic        o_res_vld,
    input  logic        i_res_rdy,
    output logic        o_busy,
    output logic        o_overrun
);
    typedef enum logic [2:0] {IDLE, ACCUM, LAUNCH, WAIT, OUT} state_t;
    state_t state;
    logic [20:0] cnt_nv, cnt_no, nv_n, no_n;
    logic [24:0] cnt_nu, nu_n;
    logic sat, sat_n, inc, timed_out;
    logic unused_busy;
    assign unused_busy = i_s1_busy;
    assign o_busy = state != IDLE;
    // Next counts include the event coinciding with frame_end, so the freeze can use them directly.
    always_comb begin
        inc   = state == ACCUM && i_evt_vld;
        nv_n  = cnt_nv + 21'(inc && i_evt_type == 2'd0 && !(&cnt_nv));
        nu_n  = cnt_nu + 25'(inc && i_evt_type == 2'd1 && !(&cnt_nu));
        no_n  = cnt_no + 21'(inc && i_evt_type == 2'd2 && !(&cnt_no));
        sat_n = sat | (inc && ((i_evt_type == 2'd0 && &cnt_nv) ||
                               (i_evt_type == 2'd1 && &cnt_nu) ||
                               (i_evt_type == 2'd2 && &cnt_no)));
    end
`ifdef S1_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    assign timed_out = to_cnt == TO_W'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk) begin
        if (rst)
            to_cnt <= '0;
        else if (state == LAUNCH)
            to_cnt <= '0;
        else if (state == WAIT)
            to_cnt <= to_cnt + 1'b1;
    end
`else
    localparam int unused_to = TIMEOUT_CYC + TO_W;
    assign timed_out = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt_nv     <= '0;
            cnt_nu     <= '0;
            cnt_no     <= '0;
            sat        <= 1'b0;
            o_nv       <= '0;
            o_nu       <= '0;
            o_no       <= '0;
            o_s1_start <= 1'b0;
            o_res_s1   <= '0;
            o_res_err  <= 1'b0;
            o_res_sat  <= 1'b0;
            o_res_vld  <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            o_s1_start <= 1'b0;
            if (i_frame_start && state != IDLE)
                o_overrun <= 1'b1;
            case (state)
                IDLE: if (i_frame_start) begin
                    cnt_nv <= '0;
                    cnt_nu <= '0;
                    cnt_no <= '0;
                    sat    <= 1'b0;
                    state  <= ACCUM;
                end
                ACCUM: begin
                    cnt_nv <= nv_n;
                    cnt_nu <= nu_n;
                    cnt_no <= no_n;
                    sat    <= sat_n;
                    if (i_frame_end) begin
                        o_nv  <= nv_n;
                        o_nu  <= nu_n;
                        o_no  <= no_n;
                        state <= LAUNCH;
                    end
                end
                LAUNCH: if (sat) begin
                    o_res_s1  <= '0;
                    o_res_err <= 1'b1;
                    o_res_sat <= 1'b1;
                    o_res_vld <= 1'b1;
                    state     <= OUT;
                end else begin
                    o_s1_start <= 1'b1;
                    state      <= WAIT;
                end
                WAIT: if (i_s1_vld || timed_out) begin
                    o_res_s1  <= (i_s1_vld && !i_s1_error) ? i_s1 : '0;
                    o_res_err <= i_s1_vld ? i_s1_error : 1'b1;
                    o_res_sat <= 1'b0;
                    o_res_vld <= 1'b1;
                    state     <= OUT;
                end
                OUT: if (i_res_rdy) begin
                    o_res_vld <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_s1_cnt_launcher.sv
// tb_s1_cnt_launcher: directed frames with a result/count scoreboard checked by decoupled monitors.
module tb_s1_cnt_launcher;
    logic clk = 1'b0, rst = 1'b1;
    logic i_frame_start = 0, i_frame_end = 0, i_evt_vld = 0;
    logic [1:0] i_evt_type = 0;
    logic [20:0] o_nv, o_no;
    logic [24:0] o_nu;
    logic o_s1_start, i_s1_busy = 0, i_s1_vld = 0, i_s1_error = 0;
    logic [31:0] i_s1 = 0, o_res_s1;
    logic o_res_err, o_res_sat, o_res_vld, i_res_rdy = 0, o_busy, o_overrun;
    int total = 0, bad = 0;

    typedef struct { logic [31:0] s1; logic err; logic sat; } res_t;
    typedef struct { logic [20:0] nv; logic [24:0] nu; logic [20:0] no; } cnt_t;
    res_t rq[$];
    cnt_t cq[$];

    s1_cnt_launcher #(.TIMEOUT_CYC(16), .TO_W(16)) dut (
        .clk(clk), .rst(rst), .i_frame_start(i_frame_start), .i_frame_end(i_frame_end),
        .i_evt_vld(i_evt_vld), .i_evt_type(i_evt_type), .o_nv(o_nv), .o_nu(o_nu), .o_no(o_no),
        .o_s1_start(o_s1_start), .i_s1_busy(i_s1_busy), .i_s1(i_s1), .i_s1_vld(i_s1_vld),
        .i_s1_error(i_s1_error), .o_res_s1(o_res_s1), .o_res_err(o_res_err), .o_res_sat(o_res_sat),
        .o_res_vld(o_res_vld), .i_res_rdy(i_res_rdy), .o_busy(o_busy), .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic send(input int t, input int n);
        repeat (n) begin
            i_evt_vld = 1;
            i_evt_type = 2'(t);
            tick;
        end
        i_evt_vld = 0;
    endtask

    task automatic frame_open;
        i_frame_start = 1;
        tick;
        i_frame_start = 0;
    endtask

    task automatic frame_close;
        i_frame_end = 1;
        tick;
        i_frame_end = 0;
    endtask

    task automatic wait_start;
        int n = 0;
        while (!o_s1_start && n < 20) begin
            tick;
            n++;
        end
        chk("start_seen", 32'(o_s1_start), 1);
    endtask

    task automatic calc_reply(input logic [31:0] s1, input logic err);
        i_s1 = s1;
        i_s1_error = err;
        i_s1_vld = 1;
        tick;
        i_s1_vld = 0;
        i_s1_error = 0;
    endtask

    // Result monitor: compares on every accepted result
    initial forever begin
        res_t r;
        @(negedge clk);
        #1;
        if (o_res_vld && i_res_rdy) begin
            chk("res_expected", 32'(rq.size() != 0), 1);
            if (rq.size() != 0) begin
                r = rq.pop_front();
                chk("res_s1", o_res_s1, r.s1);
                chk("res_err", 32'(o_res_err), 32'(r.err));
                chk("res_sat", 32'(o_res_sat), 32'(r.sat));
            end
        end
    end

    // Launch monitor: compares frozen counts on every start pulse
    initial forever begin
        cnt_t c;
        @(negedge clk);
        #1;
        if (o_s1_start) begin
            chk("start_expected", 32'(cq.size() != 0), 1);
            if (cq.size() != 0) begin
                c = cq.pop_front();
                chk("cnt_nv", 32'(o_nv), 32'(c.nv));
                chk("cnt_nu", 32'(o_nu), 32'(c.nu));
                chk("cnt_no", 32'(o_no), 32'(c.no));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick;
        chk("rst_nv", 32'(o_nv), 0);
        chk("rst_res_s1", o_res_s1, 0);
        chk("rst_res_vld", 32'(o_res_vld), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_start", 32'(o_s1_start), 0);
        chk("rst_overrun", 32'(o_overrun), 0);
        rst = 0;
        tick;
        // Events and frame_end in IDLE must be ignored
        send(0, 3);
        frame_close;
        chk("idle_busy", 32'(o_busy), 0);

        // Basic frame
        frame_open;
        chk("accum_busy", 32'(o_busy), 1);
        send(0, 10);
        send(1, 100);
        send(2, 5);
        send(3, 7);
        cq.push_back('{21'd10, 25'd100, 21'd5});
        frame_close;
        chk("start_lat1", 32'(o_s1_start), 0);
        tick;
        chk("start_lat2", 32'(o_s1_start), 1);
        tick;
        chk("start_one_cycle", 32'(o_s1_start), 0);
        repeat (7) tick;
        rq.push_back('{32'h1234, 1'b0, 1'b0});
        calc_reply(32'h1234, 0);
        chk("res_lat", 32'(o_res_vld), 1);
        for (int i = 0; i < 20; i++) begin
            chk("hold_vld", 32'(o_res_vld), 1);
            chk("hold_s1", o_res_s1, 32'h1234);
            tick;
        end
        i_res_rdy = 1;
        tick;
        i_res_rdy = 0;
        chk("accept_vld", 32'(o_res_vld), 0);
        chk("accept_busy", 32'(o_busy), 0);
        chk("accept_s1_held", o_res_s1, 32'h1234);

        // Calculator error with rdy already high
        frame_open;
        send(0, 3);
        send(1, 4);
        send(2, 5);
        cq.push_back('{21'd3, 25'd4, 21'd5});
        frame_close;
        wait_start;
        tick;
        i_res_rdy = 1;
        rq.push_back('{32'h0, 1'b1, 1'b0});
        calc_reply(32'hFFFF, 1);
        chk("err_vld", 32'(o_res_vld), 1);
        tick;
        i_res_rdy = 0;
        chk("err_vld_one_cycle", 32'(o_res_vld), 0);

        // Saturation: nv forced to one below full, last event coincides with frame_end
        frame_open;
        force dut.cnt_nv = 21'h1FFFFE;
        i_evt_vld = 1;
        i_evt_type = 0;
        #1 release dut.cnt_nv;
        tick;
        tick;
        i_frame_end = 1;
        rq.push_back('{32'h0, 1'b1, 1'b1});
        tick;
        i_frame_end = 0;
        i_evt_vld = 0;
        chk("sat_nv", 32'(o_nv), 32'h1FFFFF);
        tick;
        chk("sat_no_start", 32'(o_s1_start), 0);
        chk("sat_vld", 32'(o_res_vld), 1);
        i_res_rdy = 1;
        tick;
        i_res_rdy = 0;

`ifdef S1_TIMEOUT_EN
        // Timeout after 16 WAIT cycles
        frame_open;
        send(2, 1);
        cq.push_back('{21'd0, 25'd0, 21'd1});
        frame_close;
        wait_start;
        repeat (15) tick;
        chk("to_not_yet", 32'(o_res_vld), 0);
        tick;
        chk("to_vld", 32'(o_res_vld), 1);
        rq.push_back('{32'h0, 1'b1, 1'b0});
        i_res_rdy = 1;
        tick;
        i_res_rdy = 0;
        // vld on the limit cycle wins
        frame_open;
        send(1, 2);
        cq.push_back('{21'd0, 25'd2, 21'd0});
        frame_close;
        wait_start;
        repeat (15) tick;
        rq.push_back('{32'h77, 1'b0, 1'b0});
        calc_reply(32'h77, 0);
        i_res_rdy = 1;
        tick;
        i_res_rdy = 0;
`endif

        // Normal frame with busy high at vld
        frame_open;
        send(0, 2);
        send(2, 1);
        cq.push_back('{21'd2, 25'd0, 21'd1});
        frame_close;
        wait_start;
        i_s1_busy = 1;
        rq.push_back('{32'hABCD, 1'b0, 1'b0});
        calc_reply(32'hABCD, 0);
        i_s1_busy = 0;
        i_res_rdy = 1;
        tick;
        i_res_rdy = 0;
        chk("busy_ignored_s1", o_res_s1, 32'hABCD);

        // Overrun during WAIT, then reset mid-WAIT and a stray vld
        frame_open;
        send(0, 1);
        send(1, 1);
        send(2, 1);
        cq.push_back('{21'd1, 25'd1, 21'd1});
        frame_close;
        wait_start;
        frame_open;
        chk("overrun_set", 32'(o_overrun), 1);
        chk("overrun_busy", 32'(o_busy), 1);
        rst = 1;
        tick;
        rst = 0;
        calc_reply(32'h55, 0);
        tick;
        chk("post_rst_vld", 32'(o_res_vld), 0);
        chk("post_rst_overrun", 32'(o_overrun), 0);
        chk("post_rst_nv", 32'(o_nv), 0);
        chk("post_rst_s1", o_res_s1, 0);
        chk("post_rst_busy", 32'(o_busy), 0);
        chk("res_q_empty", rq.size(), 0);
        chk("cnt_q_empty", cq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/s1_cnt_launcher.md
Name: s1_cnt_launcher

Overview:
- Front end and initiator for the s1 estimate calculator. Counts detection events per frame in three classes: vacuum (nv), decoy (nu) and signal (no).
- At frame close it freezes the counts and presents them on o_nv/o_nu/o_no. It then pulses o_s1_start and waits for the calculator's i_s1_vld.
- It captures s1 and its error flag and offers the result downstream with a valid/ready handshake. One frame is in flight at a time.

Parameters:
- TIMEOUT_CYC, 1024: max cycles from o_s1_start to i_s1_vld before the frame is declared failed. Used only with S1_TIMEOUT_EN.
- TO_W, 16: width of the timeout counter. Must satisfy TIMEOUT_CYC < 2^TO_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_frame_start  in  1  single-cycle pulse; opens the accumulation window
- i_frame_end  in  1  single-cycle pulse; closes the window
- i_evt_vld  in  1  one detection event this cycle
- i_evt_type  in  2  0=vacuum(nv), 1=decoy(nu), 2=signal(no), 3=discard
- o_nv  out  21  frozen vacuum count to calculator
- o_nu  out  25  frozen decoy count to calculator
- o_no  out  21  frozen signal count to calculator
- o_s1_start  out  1  single-cycle start pulse to calculator
- i_s1_busy  in  1  calculator busy
- i_s1  in  32  calculator result
- i_s1_vld  in  1  calculator result valid, single-cycle
- i_s1_error  in  1  calculator error flag, sampled with i_s1_vld
- o_res_s1  out  32  captured s1
- o_res_err  out  1  frame failed: calculator error, timeout or count saturation
- o_res_sat  out  1  at least one counter saturated this frame
- o_res_vld  out  1  result valid, held until accepted
- i_res_rdy  in  1  downstream accept
- o_busy  out  1  high in every state except IDLE
- o_overrun  out  1  sticky; a frame_start arrived while not in IDLE. Cleared only by rst.

Behaviour:
- Reset: state=IDLE. All counters, o_nv/o_nu/o_no, o_res_s1 = 0. o_s1_start, o_res_err, o_res_sat, o_res_vld, o_busy, o_overrun = 0. rst has priority in any state, including mid-WAIT; a late i_s1_vld after reset is ignored because the FSM is in IDLE.
- FSM states: IDLE, ACCUM, LAUNCH, WAIT, OUT.
- IDLE:
  - i_frame_start -> ACCUM, counters cleared to 0 on the same edge.
  - Events in IDLE are ignored.
  - i_frame_end in IDLE is ignored.
- ACCUM:
  - Each i_evt_vld increments the counter selected by i_evt_type. Type 3 increments nothing.
  - Counters saturate at all-ones (0x1FFFFF / 0x1FFFFFF / 0x1FFFFF). An increment attempted at all-ones sets the internal sat flag.
  - i_frame_end -> LAUNCH. An event in the same cycle as i_frame_end is counted in the closing frame.
  - i_frame_start in ACCUM sets o_overrun; counting continues uninterrupted.
- LAUNCH:
  - One cycle. o_nv/o_nu/o_no are loaded from the counters on entry.
  - If sat is set, skip the calculator: o_res_s1=0, o_res_err=1, o_res_sat=1, go to OUT.
  - Otherwise assert o_s1_start for exactly one cycle, with the counts already stable on o_nv/o_nu/o_no, then go to WAIT.
  - o_nv/o_nu/o_no stay stable until the next LAUNCH.
- WAIT:
  - On i_s1_vld: o_res_s1 = i_s1_error ? 0 : i_s1; o_res_err = i_s1_error; -> OUT.
  - i_s1_busy is informational only; a vld with busy still high is accepted.
- OUT:
  - o_res_vld=1 and all o_res_* held stable.
  - On i_res_rdy & o_res_vld: o_res_vld=0 -> IDLE. o_res_s1/err/sat hold their values until the next capture.
  - If i_res_rdy is already high on entry, vld is high for one cycle.
  - i_frame_start in LAUNCH, WAIT or OUT sets o_overrun and is dropped.
- Latency:
  - i_frame_end -> o_s1_start: 2 clocks.
  - i_s1_vld -> o_res_vld: 1 clock.
- Arithmetic: counters are unsigned. No wrap-around is permitted; saturation only.

Optional Feature:
- Macro: S1_TIMEOUT_EN.
- Defined:
  - WAIT runs a TO_W-bit counter, cleared at LAUNCH, +1 per WAIT cycle.
  - When it reaches TIMEOUT_CYC without i_s1_vld: o_res_s1=0, o_res_err=1 -> OUT.
  - If i_s1_vld arrives on the same cycle the limit is reached, the vld wins.
- Undefined:
  - No counter is synthesised; WAIT waits indefinitely for i_s1_vld.

Test Plan:
- Basic frame: frame_start; 10 type-0, 100 type-1, 5 type-2, 7 type-3 events; frame_end -> 2 clocks later o_s1_start pulses once with o_nv=10, o_nu=100, o_no=5. Model returns i_s1=0x00001234 after 9 cycles -> next clock o_res_vld=1, o_res_s1=0x1234, err=0.
- Handshake: hold i_res_rdy=0 for 20 cycles -> o_res_vld and o_res_s1 stable throughout; rdy=1 -> vld drops next clock, o_busy=0.
- Calculator error: i_s1_vld with i_s1_error=1, i_s1=0xFFFF -> o_res_s1=0, o_res_err=1.
- Saturation and boundary: force o_nv counter to 0x1FFFFE, send 3 type-0 events with the last coinciding with frame_end -> o_nv=0x1FFFFF, no o_s1_start, o_res_err=1, o_res_sat=1.
- Timeout (S1_TIMEOUT_EN, TIMEOUT_CYC=16): no i_s1_vld -> o_res_vld after 16 WAIT cycles, o_res_err=1. Same build with vld on the 16th cycle -> err=0, s1 captured.
- Overrun/reset: frame_start during WAIT -> o_overrun=1, frame dropped. rst mid-WAIT, then a stray i_s1_vld -> all outputs at reset values, o_res_vld stays 0.
